timing_arc_reader: RTL and testbench
====================================

Name: timing_arc_reader

Overview:
- Hardware reader for the team's cell-timing arc library.
- A host loads per-arc pin-to-pin delays, in fixed-point, into an internal arc table.
- A path stream then presents arc IDs, one per beat. The block looks each one up, accumulates the path delay and returns one result per path.
- Sits beside the PrimerTime timing flow as an on-chip path-delay evaluator.

Parameters:
- ARC_AW, 6: arc-table address width; the table holds 2**ARC_AW arcs.
- DLY_W, 16: width of one arc delay, unsigned, 1 LSB = 1/1024 ns.
- SUM_W, 20: path-delay accumulator width, SUM_W >= DLY_W.
- CNT_W, 8: arc-count width per path.

Ports:
- CP  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ARC_AW  arc ID to write.
- wr_data  in  DLY_W  arc delay; the write also sets the entry's loaded bit.
- q_valid  in  1  query beat valid.
- q_ready  out  1  block can accept a query beat.
- q_arc  in  ARC_AW  arc ID to look up.
- q_last  in  1  final arc of the current path.
- r_valid  out  1  path result valid.
- r_ready  in  1  consumer accepts the result.
- r_delay  out  SUM_W  accumulated path delay.
- r_arcs  out  CNT_W  number of arcs in the path.
- r_sat  out  1  delay or count saturated.
- r_err  out  1  path referenced an unloaded arc.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Drives q_ready=0 in the reset cycle, q_ready=1 in the next cycle.
  - r_valid=0; r_delay, r_arcs, r_sat and r_err = 0.
  - State = ACC; accumulators cleared.
  - All table loaded bits cleared; table data is not cleared.
  - RST asserted mid-path or during DONE discards the path; no result is produced.
- Table:
  - Synchronous read, one-cycle latency.
  - A write and a lookup to the same address in the same cycle: the lookup returns the old data and old loaded bit. The write is visible from the next cycle.
  - Writes are accepted in every state.
- Pipeline, throughput 1 arc/cycle:
  - S0: handshake q_valid & q_ready; the arc is read from the table.
  - S1: registered delay added to the accumulator; count incremented; r_err |= !loaded.
- FSM:
  - ACC: q_ready=1. Accepting a beat with q_last=1 sets last_pend and drops q_ready the next cycle.
  - When the last beat's S1 completes: go to DONE, r_valid=1 with the final values, 2 cycles after the last handshake.
  - DONE: q_ready=0; outputs held stable while r_valid & !r_ready.
  - On r_valid & r_ready: clear the accumulators; return to ACC with q_ready=1 in the next cycle.
- Arithmetic:
  - Unsigned adds.
  - On overflow the sum clamps to 2**SUM_W-1 and r_sat=1; it never wraps.
  - The count also clamps at 2**CNT_W-1 with r_sat=1.
  - An unloaded arc contributes delay 0.
- Single-beat path (q_last on the first beat): legal, r_arcs=1.
- No empty paths exist; a path ends only on q_last.

Optional Feature:
- TIMING_WORST_ARC_EN, when defined:
  - Adds outputs r_worst_dly [DLY_W] and r_worst_arc [ARC_AW].
  - These report the largest single arc delay in the path and its ID; the first occurrence wins on ties.
  - Updated in S1; reset to 0; held in DONE like the other r_* outputs.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package timing_arc_pkg holds:
  - the default widths;
  - the delay scale constant DLY_LSB_PER_NS=1024;
  - the FSM state enum {ACC, DONE};
  - the saturating-add function.
- One sub-module, timing_arc_table: the 2**ARC_AW x (DLY_W+1) synchronous-read RAM with the loaded bit, read-old-data on collision, and loaded-bit clear on reset.

Test Plan:
- Load arc0=555 (INVD1 I->ZN), arc1=4986 (DFQD1 CP->Q), arc2=5679 (FA1D1 A->CO). Path 1,0,2 with q_last on arc2 -> r_valid 2 cycles after the last beat; r_delay=11220, r_arcs=3, r_sat=0, r_err=0.
- Single-beat path on arc0 -> r_delay=555, r_arcs=1. Then hold r_ready=0 for 5 cycles -> outputs stable, q_ready=0; after r_ready=1 -> q_ready=1 the next cycle.
- SUM_W=16: 12 beats of arc2 -> r_delay=65535, r_sat=1, r_arcs=12.
- Query arc5, never loaded, then arc0 with last -> r_err=1, r_delay=555. The next path, on arc0 only -> r_err=0.
- Same cycle: write arc0=100 and query arc0 with last -> r_delay=555. Next path on arc0 -> r_delay=100.
- Assert RST after 2 beats of a path -> no r_valid; arc0 now unloaded (r_err=1 on the next query); with TIMING_WORST_ARC_EN, the first test reports r_worst_arc=2, r_worst_dly=5679.

Source files
------------

// File: rtl/timing_arc_pkg.sv
// Shared definitions for the timing arc reader.
// Holds the default widths, the delay scale, the FSM state type and the
// saturating-add helpers used by the path accumulator.
package timing_arc_pkg;

  localparam int ARC_AW_DEF = 6;
  localparam int DLY_W_DEF  = 16;
  localparam int SUM_W_DEF  = 20;
  localparam int CNT_W_DEF  = 8;

  // One delay LSB is 1/1024 ns.
  localparam int DLY_LSB_PER_NS = 1024;

  typedef enum logic {
    ACC,
    DONE
  } state_e;

  // Unsigned add that clamps to 2**w-1 instead of wrapping.
  // Operands are assumed to already fit in w bits, with w well below 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] max_v;
    logic [63:0] s;
    max_v = (64'd1 << w) - 64'd1;
    s     = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

  // True when a + b would exceed the w-bit range and sat_add clamps.
  function automatic logic add_ovf(input logic [63:0] a,
                                   input logic [63:0] b,
                                   input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (a + b) > max_v;
  endfunction

endpackage

// File: rtl/timing_arc_reader_if.sv
// Host-facing bus of the timing arc reader: table write port, query stream
// and result handshake. The master side is the host, the slave side the reader.
// Optional macro TIMING_WORST_ARC_EN adds the worst-arc result fields.
interface timing_arc_reader_if #(
  parameter int ARC_AW = 6,
  parameter int DLY_W  = 16,
  parameter int SUM_W  = 20,
  parameter int CNT_W  = 8
) ();

  logic              wr_en;
  logic [ARC_AW-1:0] wr_addr;
  logic [DLY_W-1:0]  wr_data;

  logic              q_valid;
  logic              q_ready;
  logic [ARC_AW-1:0] q_arc;
  logic              q_last;

  logic              r_valid;
  logic              r_ready;
  logic [SUM_W-1:0]  r_delay;
  logic [CNT_W-1:0]  r_arcs;
  logic              r_sat;
  logic              r_err;

`ifdef TIMING_WORST_ARC_EN
  logic [DLY_W-1:0]  r_worst_dly;
  logic [ARC_AW-1:0] r_worst_arc;

  modport master (
    output wr_en, wr_addr, wr_data, q_valid, q_arc, q_last, r_ready,
    input  q_ready, r_valid, r_delay, r_arcs, r_sat, r_err,
           r_worst_dly, r_worst_arc
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, q_valid, q_arc, q_last, r_ready,
    output q_ready, r_valid, r_delay, r_arcs, r_sat, r_err,
           r_worst_dly, r_worst_arc
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, q_valid, q_arc, q_last, r_ready,
    input  q_ready, r_valid, r_delay, r_arcs, r_sat, r_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, q_valid, q_arc, q_last, r_ready,
    output q_ready, r_valid, r_delay, r_arcs, r_sat, r_err
  );
`endif

endinterface

// File: rtl/timing_arc_table.sv
// Arc delay table: 2**ARC_AW entries of delay plus a loaded bit.
// Synchronous read with one cycle of latency; a same-cycle write to the
// address being read returns the old data and old loaded bit.
// Reset clears the loaded bits only, the delay storage keeps its contents.
module timing_arc_table
  import timing_arc_pkg::*;
#(
  parameter int ARC_AW = ARC_AW_DEF,
  parameter int DLY_W  = DLY_W_DEF
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ARC_AW-1:0] wr_addr,
  input  logic [DLY_W-1:0]  wr_data,
  input  logic [ARC_AW-1:0] rd_addr,
  output logic [DLY_W-1:0]  rd_data,
  output logic              rd_loaded
);

  localparam int DEPTH = 2 ** ARC_AW;

  logic [DLY_W-1:0] mem [DEPTH];
  logic [DLY_W-1:0] rd_data_q;
  logic [DEPTH-1:0] loaded_q, loaded_d;
  logic             rd_loaded_q, rd_loaded_d;

  // Delay storage and its read register; no reset so it maps onto block RAM.
  always_ff @(posedge CP) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Loaded-bit update and read, both taken from the pre-write state.
  always_comb begin
    loaded_d    = loaded_q;
    rd_loaded_d = loaded_q[rd_addr];
    if (wr_en) begin
      loaded_d[wr_addr] = 1'b1;
    end
  end

  // Loaded bits are the only table state that reset clears.
  always_ff @(posedge CP) begin
    if (RST) begin
      loaded_q    <= '0;
      rd_loaded_q <= 1'b0;
    end else begin
      loaded_q    <= loaded_d;
      rd_loaded_q <= rd_loaded_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_loaded = rd_loaded_q;

endmodule

// File: rtl/timing_arc_reader.sv
// Path-delay evaluator: looks up each arc of an incoming path in the arc
// table, accumulates a saturating path delay and arc count, flags unloaded
// arcs, and hands back one result per path.
// Pipeline: S0 accepts the beat and reads the table, S1 accumulates.
// Optional macro TIMING_WORST_ARC_EN also reports the worst single arc.
module timing_arc_reader
  import timing_arc_pkg::*;
#(
  parameter int ARC_AW = ARC_AW_DEF,
  parameter int DLY_W  = DLY_W_DEF,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic CP,
  input logic RST,
  timing_arc_reader_if.slave bus
);

  state_e            state_q, state_d;
  logic              last_pend_q, last_pend_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  logic              q_fire;
  logic [DLY_W-1:0]  tbl_data;
  logic              tbl_loaded;
  logic [DLY_W-1:0]  arc_dly;

`ifdef TIMING_WORST_ARC_EN
  logic [ARC_AW-1:0] s1_arc_q, s1_arc_d;
  logic [DLY_W-1:0]  worst_dly_q, worst_dly_d;
  logic [ARC_AW-1:0] worst_arc_q, worst_arc_d;
`endif

  // Beats are taken only in ACC with no finished path still draining
  // through S1, and never while reset is being applied.
  assign bus.q_ready = !RST && (state_q == ACC) && !last_pend_q;
  assign q_fire      = bus.q_valid && bus.q_ready;

  timing_arc_table #(
    .ARC_AW (ARC_AW),
    .DLY_W  (DLY_W)
  ) u_table (
    .CP        (CP),
    .RST       (RST),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .rd_addr   (bus.q_arc),
    .rd_data   (tbl_data),
    .rd_loaded (tbl_loaded)
  );

  // An unloaded arc adds nothing to the path delay.
  assign arc_dly = tbl_loaded ? tbl_data : '0;

  // Next-state logic: S0 capture, S1 accumulation, result hand-off.
  always_comb begin
    state_d     = state_q;
    last_pend_d = last_pend_q;
    s1_valid_d  = q_fire;
    s1_last_d   = q_fire && bus.q_last;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    err_d       = err_q;
`ifdef TIMING_WORST_ARC_EN
    s1_arc_d    = bus.q_arc;
    worst_dly_d = worst_dly_q;
    worst_arc_d = worst_arc_q;
`endif

    if (q_fire && bus.q_last) begin
      last_pend_d = 1'b1;
    end

    case (state_q)
      ACC: begin
        if (s1_valid_q) begin
          sum_d = SUM_W'(sat_add(64'(sum_q), 64'(arc_dly), SUM_W));
          cnt_d = CNT_W'(sat_add(64'(cnt_q), 64'd1, CNT_W));
          sat_d = sat_q
                  | add_ovf(64'(sum_q), 64'(arc_dly), SUM_W)
                  | add_ovf(64'(cnt_q), 64'd1, CNT_W);
          err_d = err_q | !tbl_loaded;
`ifdef TIMING_WORST_ARC_EN
          if (arc_dly > worst_dly_q) begin
            worst_dly_d = arc_dly;
            worst_arc_d = s1_arc_q;
          end
`endif
          if (s1_last_q) begin
            state_d     = DONE;
            last_pend_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.r_ready) begin
          state_d = ACC;
          sum_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          err_d   = 1'b0;
`ifdef TIMING_WORST_ARC_EN
          worst_dly_d = '0;
          worst_arc_d = '0;
`endif
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and accumulator registers; reset discards any path in flight.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q     <= ACC;
      last_pend_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef TIMING_WORST_ARC_EN
      s1_arc_q    <= '0;
      worst_dly_q <= '0;
      worst_arc_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_pend_q <= last_pend_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
`ifdef TIMING_WORST_ARC_EN
      s1_arc_q    <= s1_arc_d;
      worst_dly_q <= worst_dly_d;
      worst_arc_q <= worst_arc_d;
`endif
    end
  end

  assign bus.r_valid = (state_q == DONE);
  assign bus.r_delay = sum_q;
  assign bus.r_arcs  = cnt_q;
  assign bus.r_sat   = sat_q;
  assign bus.r_err   = err_q;
`ifdef TIMING_WORST_ARC_EN
  assign bus.r_worst_dly = worst_dly_q;
  assign bus.r_worst_arc = worst_arc_q;
`endif

endmodule

// File: tb/tb_timing_arc_reader.sv
// Testbench for timing_arc_reader: directed library scenarios followed by
// random paths, all checked against a path-level reference model.
// The DUT is built with a 16-bit accumulator so that delay saturation is
// reachable within a handful of beats.
// Optional macro TIMING_WORST_ARC_EN enables the worst-arc checks.
module tb_timing_arc_reader;
  import timing_arc_pkg::*;

  localparam int ARC_AW = 6;
  localparam int DLY_W  = 16;
  localparam int SUM_W  = 16;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 2 ** ARC_AW;

  logic CP  = 1'b0;
  logic RST = 1'b1;

  timing_arc_reader_if #(
    .ARC_AW (ARC_AW), .DLY_W (DLY_W), .SUM_W (SUM_W), .CNT_W (CNT_W)
  ) bus ();

  timing_arc_reader #(
    .ARC_AW (ARC_AW), .DLY_W (DLY_W), .SUM_W (SUM_W), .CNT_W (CNT_W)
  ) dut (
    .CP  (CP),
    .RST (RST),
    .bus (bus)
  );

  always #5 CP = ~CP;

  int checkCount = 0;
  int failCount  = 0;

  // Reference view of the arc table.
  int modelDly [DEPTH];
  bit modelLoaded [DEPTH];

  // Arcs of the path currently being sent, as looked up when accepted.
  int pathArc [$];
  int pathDly [$];
  bit pathLoaded [$];

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearModelLoaded();
    for (int i = 0; i < DEPTH; i++) modelLoaded[i] = 1'b0;
  endtask

  task automatic writeArc(input int addr, input int dly);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ARC_AW'(addr);
    bus.wr_data = DLY_W'(dly);
    @(negedge CP);
    bus.wr_en = 1'b0;
    modelDly[addr]    = dly;
    modelLoaded[addr] = 1'b1;
  endtask

  // One query beat, optionally with a table write in the same cycle.
  task automatic applyStimulus(input int arc, input bit last,
                               input bit doWrite, input int wa, input int wd);
    checkOutput("q_ready_at_beat", bus.q_ready, 1);
    bus.q_valid = 1'b1;
    bus.q_arc   = ARC_AW'(arc);
    bus.q_last  = last;
    if (doWrite) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ARC_AW'(wa);
      bus.wr_data = DLY_W'(wd);
    end
    pathArc.push_back(arc);
    pathDly.push_back(modelLoaded[arc] ? modelDly[arc] : 0);
    pathLoaded.push_back(modelLoaded[arc]);
    @(negedge CP);
    bus.q_valid = 1'b0;
    bus.q_last  = 1'b0;
    bus.wr_en   = 1'b0;
    if (doWrite) begin
      modelDly[wa]    = wd;
      modelLoaded[wa] = 1'b1;
    end
  endtask

  // Wait for the result of the path just sent, check it, hold it for
  // holdCycles with r_ready low, then accept it.
  task automatic finishPath(input string name, input int holdCycles);
    longint total;
    longint maxSum;
    longint expDelay;
    int     n;
    int     maxCnt;
    int     expArcs;
    bit     expSat;
    bit     expErr;
    int     worstDly;
    int     worstArc;
    int     lat;

    total    = 0;
    maxSum   = (longint'(1) << SUM_W) - 1;
    maxCnt   = (1 << CNT_W) - 1;
    n        = pathDly.size();
    expErr   = 1'b0;
    worstDly = 0;
    worstArc = 0;
    foreach (pathDly[i]) begin
      total += pathDly[i];
      if (!pathLoaded[i]) expErr = 1'b1;
      if (pathDly[i] > worstDly) begin
        worstDly = pathDly[i];
        worstArc = pathArc[i];
      end
    end
    expDelay = (total > maxSum) ? maxSum : total;
    expArcs  = (n > maxCnt) ? maxCnt : n;
    expSat   = (total > maxSum) || (n > maxCnt);

    lat = 1;
    checkOutput({name, "_r_valid_early"}, bus.r_valid, 0);
    while (!bus.r_valid && lat < 12) begin
      @(negedge CP);
      lat++;
    end
    checkOutput({name, "_latency"}, lat, 2);

    for (int h = 0; h <= holdCycles; h++) begin
      if (h > 0) @(negedge CP);
      checkOutput({name, "_r_valid"}, bus.r_valid, 1);
      checkOutput({name, "_r_delay"}, bus.r_delay, expDelay);
      checkOutput({name, "_r_arcs"}, bus.r_arcs, expArcs);
      checkOutput({name, "_r_sat"}, bus.r_sat, expSat);
      checkOutput({name, "_r_err"}, bus.r_err, expErr);
      checkOutput({name, "_q_ready_done"}, bus.q_ready, 0);
`ifdef TIMING_WORST_ARC_EN
      checkOutput({name, "_r_worst_dly"}, bus.r_worst_dly, worstDly);
      checkOutput({name, "_r_worst_arc"}, bus.r_worst_arc, worstArc);
`endif
    end

    bus.r_ready = 1'b1;
    @(negedge CP);
    bus.r_ready = 1'b0;
    checkOutput({name, "_r_valid_cleared"}, bus.r_valid, 0);
    checkOutput({name, "_q_ready_back"}, bus.q_ready, 1);

    pathArc.delete();
    pathDly.delete();
    pathLoaded.delete();
  endtask

  initial begin
    int len;
    int arc;
    bit doWrite;
    int wa;
    int wd;

    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.q_valid = 1'b0;
    bus.q_arc   = '0;
    bus.q_last  = 1'b0;
    bus.r_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) modelDly[i] = 0;
    clearModelLoaded();

    // Reset: q_ready low during the reset cycle, idle outputs afterwards.
    #1;
    checkOutput("reset_q_ready_low", bus.q_ready, 0);
    @(negedge CP);
    RST = 1'b0;
    @(negedge CP);
    checkOutput("reset_q_ready", bus.q_ready, 1);
    checkOutput("reset_r_valid", bus.r_valid, 0);
    checkOutput("reset_r_delay", bus.r_delay, 0);
    checkOutput("reset_r_arcs", bus.r_arcs, 0);
    checkOutput("reset_r_sat", bus.r_sat, 0);
    checkOutput("reset_r_err", bus.r_err, 0);

    // Library load and a three-arc path: 4986 + 555 + 5679.
    writeArc(0, 555);
    writeArc(1, 4986);
    writeArc(2, 5679);
    applyStimulus(1, 1'b0, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 1'b0, 0, 0);
    applyStimulus(2, 1'b1, 1'b0, 0, 0);
    checkOutput("path3_expected_total", pathDly[0] + pathDly[1] + pathDly[2], 11220);
    finishPath("path3", 0);

    // Single-beat path, result held under back-pressure.
    applyStimulus(0, 1'b1, 1'b0, 0, 0);
    finishPath("single", 5);

    // Delay saturation: 12 x 5679 exceeds 16 bits.
    for (int i = 0; i < 12; i++) applyStimulus(2, i == 11, 1'b0, 0, 0);
    finishPath("dly_sat", 1);

    // Unloaded arc flags the path, and only that path.
    applyStimulus(5, 1'b0, 1'b0, 0, 0);
    applyStimulus(0, 1'b1, 1'b0, 0, 0);
    finishPath("unloaded", 0);
    applyStimulus(0, 1'b1, 1'b0, 0, 0);
    finishPath("err_clear", 0);

    // Same-cycle write and lookup of arc0: old value first, new value after.
    applyStimulus(0, 1'b1, 1'b1, 0, 100);
    finishPath("collide_old", 0);
    applyStimulus(0, 1'b1, 1'b0, 0, 0);
    finishPath("collide_new", 0);

    // Count saturation: 260 beats of a 1-LSB arc.
    writeArc(3, 1);
    for (int i = 0; i < 260; i++) applyStimulus(3, i == 259, 1'b0, 0, 0);
    finishPath("cnt_sat", 0);

    // Reset mid-path: path discarded, loaded bits cleared.
    applyStimulus(1, 1'b0, 1'b0, 0, 0);
    applyStimulus(2, 1'b0, 1'b0, 0, 0);
    RST = 1'b1;
    #1;
    checkOutput("midrst_q_ready_low", bus.q_ready, 0);
    @(negedge CP);
    RST = 1'b0;
    pathArc.delete();
    pathDly.delete();
    pathLoaded.delete();
    clearModelLoaded();
    for (int i = 0; i < 4; i++) begin
      @(negedge CP);
      checkOutput("midrst_no_result", bus.r_valid, 0);
    end
    checkOutput("midrst_r_arcs", bus.r_arcs, 0);
    applyStimulus(0, 1'b1, 1'b0, 0, 0);
    finishPath("after_rst", 0);

    // Random table contents and random paths with occasional collisions.
    for (int i = 0; i < 12; i++) writeArc(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
    for (int p = 0; p < 40; p++) begin
      len = int'($urandom_range(1, 8));
      for (int b = 0; b < len; b++) begin
        arc     = int'($urandom_range(0, 15));
        doWrite = ($urandom_range(0, 3) == 0);
        wa      = ($urandom_range(0, 1) == 0) ? arc : int'($urandom_range(0, 15));
        wd      = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9000)) : int'($urandom_range(0, 65535));
        applyStimulus(arc, b == len - 1, doWrite, wa, wd);
      end
      finishPath("random", int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  // Global watchdog in case the stimulus thread stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
